// File: rtl/gray_pkg.sv
// -----------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-code counter block.
//   GRAY_DEFAULT_WIDTH : default counter width.
//   GRAY_MAX_WIDTH     : width of the generic helper-function arguments.
//   bin2gray()         : binary -> Gray (bin ^ (bin >> 1)).
//   gray2bin()         : Gray -> binary, for verification models and debug.
// -----------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_DEFAULT_WIDTH = 8;
    localparam int GRAY_MAX_WIDTH     = 32;

    typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it, so walk
    // down from the MSB carrying the running XOR.
    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin = '0;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_encode.sv
// -----------------------------------------------------------------------------
// gray_encode
// Purely combinational binary-to-Gray converter.
//   bin  : WIDTH-bit binary input.
//   gray : WIDTH-bit Gray-code output, gray = bin ^ (bin >> 1).
// -----------------------------------------------------------------------------
module gray_encode
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // The MSB passes straight through; every lower bit is the XOR of
    // itself and its upper neighbour.
    assign gray[WIDTH-1] = bin[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign gray[gi] = bin[gi] ^ bin[gi+1];
        end
    endgenerate

endmodule

// File: rtl/gray_counter.sv
// -----------------------------------------------------------------------------
// gray_counter
// Free-running Gray-code up-counter with enable, synchronous clear and a
// one-cycle wrap pulse. A binary count is kept internally; its Gray encoding
// is registered on the output so count has no combinational input path.
//   clk       : rising-edge clock.
//   rst       : synchronous reset, active-high, highest priority.
//   count_en  : advance by one step per clock when high.
//   count_clr : synchronous clear, active-high, overrides count_en.
//   count     : registered Gray-code count (WIDTH bits, WIDTH >= 2).
//   overflow  : registered one-cycle pulse when the count wraps to zero.
// -----------------------------------------------------------------------------
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             count_en,
    input  logic             count_clr,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             overflow_reg;
    logic             overflow_next;

    // Next binary value: clear beats enable, otherwise hold. The carry out
    // of the increment is the wrap indication; a clear on the wrap cycle
    // suppresses it.
    always_comb begin
        bin_next      = bin_reg;
        overflow_next = 1'b0;
        if (count_clr) begin
            bin_next = '0;
        end else if (count_en) begin
            bin_next      = bin_reg + 1'b1;
            overflow_next = &bin_reg;
        end
    end

    // Encode the next binary value so the Gray register updates in the same
    // edge as the binary register and the two never disagree.
    gray_encode #(
        .WIDTH (WIDTH)
    ) u_gray_encode (
        .bin  (bin_next),
        .gray (count_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg      <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            bin_reg      <= bin_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_gray_counter.sv
// -----------------------------------------------------------------------------
// tb_gray_counter
// Self-checking bench for gray_counter (WIDTH = 8). A behavioural model keeps
// an integer step counter and derives the expected Gray value and wrap flag
// arithmetically; directed sequences are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_gray_counter;

    localparam int W   = 8;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         count_en;
    logic         count_clr;
    logic [W-1:0] count;
    logic         overflow;

    int tests;
    int fails;

    // Reference model state
    int   m_n;
    logic m_ovf;
    int   ovf_seen;
    logic [W-1:0] prev_count;

    gray_counter #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .count_en  (count_en),
        .count_clr (count_clr),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int gray_of(input int n);
        return n ^ (n / 2);
    endfunction

    // One clock step: drive on the falling edge, sample 1 time unit after the
    // rising edge, advance the model and compare.
    task automatic step(input logic r, input logic c, input logic e, input string tag);
        @(negedge clk);
        rst        = r;
        count_clr  = c;
        count_en   = e;
        prev_count = count;
        @(posedge clk);
        #1;
        if (r || c) begin
            m_n   = 0;
            m_ovf = 1'b0;
        end else if (e) begin
            m_ovf = (m_n == MOD - 1);
            m_n   = (m_n + 1) % MOD;
        end else begin
            m_ovf = 1'b0;
        end
        if (overflow === 1'b1) ovf_seen++;
        check({tag, ".count"}, 32'(count), 32'(gray_of(m_n)));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        if (!r && !c && e) begin
            check({tag, ".onebit"}, 32'($countones(prev_count ^ count)), 32'd1);
        end
        $display("[TB] %s rst=%0b clr=%0b en=%0b count=%02h ovf=%0b", tag, r, c, e, count, overflow);
    endtask

    initial begin
        logic [W-1:0] tab [11];
        int           r_draw;

        tests    = 0;
        fails    = 0;
        m_n      = 0;
        m_ovf    = 1'b0;
        ovf_seen = 0;
        rst       = 1'b1;
        count_en  = 1'b0;
        count_clr = 1'b0;

        // Reset behaviour
        step(1, 0, 0, "init");
        repeat (5) step(0, 0, 1, "pre_rst");
        repeat (2) step(1, 0, 1, "rst");
        check("rst.count0", 32'(count), 32'h00);
        check("rst.ovf0", 32'(overflow), 32'h0);
        repeat (2) step(0, 0, 0, "rst_hold");
        check("rst_hold.count0", 32'(count), 32'h00);

        // Enable / hold against literal sequence
        tab = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07,
                8'h07, 8'h07, 8'h07, 8'h05, 8'h04, 8'h0C};
        for (int i = 0; i < 11; i++) begin
            step(0, 0, (i < 5 || i > 7), "enhold");
            check($sformatf("enhold.tab%0d", i), 32'(count), 32'(tab[i]));
        end

        // Clear has priority over enable
        step(0, 1, 1, "clr_pri");
        check("clr_pri.count", 32'(count), 32'h00);
        check("clr_pri.ovf", 32'(overflow), 32'h0);
        step(0, 0, 0, "clr_hold");

        // Full sequence with wrap, plus overflow exclusivity over 260 cycles
        step(1, 0, 0, "full_rst");
        ovf_seen = 0;
        for (int n = 1; n <= 260; n++) begin
            step(0, 0, 1, "full");
            if (n == 170) begin
                check("full.ff", 32'(count), 32'hFF);
                check("full.ff_ovf", 32'(overflow), 32'h0);
            end
            if (n == 255) begin
                check("full.e255", 32'(count), 32'h80);
                check("full.e255_ovf", 32'(overflow), 32'h0);
            end
            if (n == 256) begin
                check("full.e256", 32'(count), 32'h00);
                check("full.e256_ovf", 32'(overflow), 32'h1);
            end
            if (n == 257) begin
                check("full.e257", 32'(count), 32'h01);
                check("full.e257_ovf", 32'(overflow), 32'h0);
            end
        end
        check("full.ovf_pulses", 32'(ovf_seen), 32'd1);

        // Overflow returns low when holding right after the wrap
        step(1, 0, 0, "wraphold_rst");
        repeat (256) step(0, 0, 1, "wraphold");
        check("wraphold.ovf", 32'(overflow), 32'h1);
        step(0, 0, 0, "wraphold_off");
        check("wraphold.ovf_off", 32'(overflow), 32'h0);

        // Clear exactly at the wrap point: no pulse
        step(1, 0, 0, "clrwrap_rst");
        repeat (255) step(0, 0, 1, "clrwrap");
        check("clrwrap.at80", 32'(count), 32'h80);
        step(0, 1, 1, "clrwrap_clr");
        check("clrwrap.count", 32'(count), 32'h00);
        check("clrwrap.ovf", 32'(overflow), 32'h0);

        // Randomized phase: mostly counting with occasional clear / reset
        for (int i = 0; i < 700; i++) begin
            r_draw = int'($urandom_range(0, 99));
            step((r_draw < 2), (r_draw >= 2 && r_draw < 5),
                 ($urandom_range(0, 3) != 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case anything stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
